// File: rtl/dbg_telemetry_pkg.sv
// Shared definitions for the debug telemetry transmitter.
// Contents: frame length, default sync byte, byte-index constants, the
// frame FSM state enum, the snapshot record, and a helper that selects a
// payload byte (bytes 1..11) out of a snapshot.
package dbg_telemetry_pkg;

  localparam int         FRAME_LEN    = 13;
  localparam logic [7:0] SYNC_DEFAULT = 8'hA5;

  // Byte positions inside a frame
  localparam int IDX_SYNC   = 0;
  localparam int IDX_SEQ    = 1;
  localparam int IDX_STATUS = 2;
  localparam int IDX_UART   = 3;
  localparam int IDX_ACC0   = 4;
  localparam int IDX_ACC1   = 8;
  localparam int IDX_CHK    = FRAME_LEN - 1;

  typedef enum logic [1:0] {IDLE, SEND, DRAIN} tx_state_e;

  // Field order matches the concatenation used at capture time
  typedef struct packed {
    logic        acc_valid;
    logic [2:0]  mlp_layer;
    logic [3:0]  mlp_state;
    logic        layer_complete;
    logic [3:0]  uart_state;
    logic [31:0] acc0;
    logic [31:0] acc1;
  } snap_t;

  // Payload bytes 1..11; sync and checksum positions are handled by the caller
  function automatic logic [7:0] payload_byte(input snap_t s, input logic [7:0] seq,
                                              input logic [3:0] idx);
    logic [7:0] b;
    case (idx)
      4'(IDX_SEQ):      b = seq;
      4'(IDX_STATUS):   b = {s.acc_valid, s.mlp_layer, s.mlp_state};
      4'(IDX_UART):     b = {s.layer_complete, 3'b000, s.uart_state};
      4'(IDX_ACC0):     b = s.acc0[7:0];
      4'(IDX_ACC0 + 1): b = s.acc0[15:8];
      4'(IDX_ACC0 + 2): b = s.acc0[23:16];
      4'(IDX_ACC0 + 3): b = s.acc0[31:24];
      4'(IDX_ACC1):     b = s.acc1[7:0];
      4'(IDX_ACC1 + 1): b = s.acc1[15:8];
      4'(IDX_ACC1 + 2): b = s.acc1[23:16];
      4'(IDX_ACC1 + 3): b = s.acc1[31:24];
      default:          b = 8'h00;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/dbg_telemetry_tx_serializer.sv
// uart_tx_serializer: generic 8N1 UART transmitter.
// Ports:
//   clk_100mhz, rst   clock, synchronous active-high reset
//   in_data, in_valid byte to send and its handshake qualifier
//   in_ready          high when idle or in the last cycle of a stop bit, so a
//                     waiting byte follows the previous one with no gap
//   tx                registered serial line, idles high
//   tx_active         high while a character is on the line
module uart_tx_serializer #(
  parameter int CLOCK_FREQ = 100_000_000,
  parameter int BAUD_RATE  = 115200
) (
  input  logic       clk_100mhz,
  input  logic       rst,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  output logic       tx,
  output logic       tx_active
);

  localparam int            BIT_CYCLES = CLOCK_FREQ / BAUD_RATE;
  localparam int            CW         = $clog2(BIT_CYCLES);
  localparam logic [CW-1:0] BIT_LAST   = CW'(BIT_CYCLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} ser_state_e;

  ser_state_e    state;
  logic [CW-1:0] bit_cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shreg;
  logic          bit_end;

  assign bit_end   = (bit_cnt == BIT_LAST);
  assign in_ready  = (state == S_IDLE) || ((state == S_STOP) && bit_end);
  assign tx_active = (state != S_IDLE);

  always_ff @(posedge clk_100mhz) begin
    if (rst) begin
      state   <= S_IDLE;
      bit_cnt <= '0;
      bit_idx <= '0;
      shreg   <= '0;
      tx      <= 1'b1;
    end else if (in_valid && in_ready) begin
      // Load takes priority so a new start bit directly follows a stop bit
      state   <= S_START;
      shreg   <= in_data;
      bit_cnt <= '0;
      bit_idx <= '0;
      tx      <= 1'b0;
    end else if (state != S_IDLE) begin
      if (!bit_end) begin
        bit_cnt <= bit_cnt + 1'b1;
      end else begin
        bit_cnt <= '0;
        case (state)
          S_START: begin
            state <= S_DATA;
            tx    <= shreg[0];
            shreg <= shreg >> 1;
          end
          S_DATA: begin
            if (bit_idx == 3'd7) begin
              state <= S_STOP;
              tx    <= 1'b1;
            end else begin
              bit_idx <= bit_idx + 1'b1;
              tx      <= shreg[0];
              shreg   <= shreg >> 1;
            end
          end
          default: begin
            state <= S_IDLE;
            tx    <= 1'b1;
          end
        endcase
      end
    end
  end

endmodule

// File: rtl/dbg_telemetry_tx.sv
// dbg_telemetry_tx: snapshots TPU / UART-controller debug state and streams
// it to the host as 13-byte frames on a dedicated 8N1 line.
// Frame: A5 | seq | {acc_valid,layer,state} | {layer_complete,000,uart_state}
//        | acc0 LE | acc1 LE | XOR(bytes 1..11)
// Ports:
//   clk_100mhz, rst   clock, synchronous active-high reset
//   enable            periodic timer enable (timer held at 0 when low)
//   trigger           single-cycle frame request
//   mlp_*, layer_complete, acc_valid, acc0, acc1, uart_state  debug inputs
//   tx                serial output, idles high
//   busy              capture through the end of the final stop bit
//   frame_count       sequence number of the last frame started
//   dropped           one-cycle pulse when a request arrives while busy
module dbg_telemetry_tx
  import dbg_telemetry_pkg::*;
#(
  parameter int         CLOCK_FREQ    = 100_000_000,
  parameter int         BAUD_RATE     = 115200,
  parameter int         PERIOD_CYCLES = 10_000_000,
  parameter logic [7:0] SYNC_BYTE     = SYNC_DEFAULT
) (
  input  logic        clk_100mhz,
  input  logic        rst,
  input  logic        enable,
  input  logic        trigger,
  input  logic [3:0]  mlp_state,
  input  logic [2:0]  mlp_layer,
  input  logic        layer_complete,
  input  logic        acc_valid,
  input  logic [31:0] acc0,
  input  logic [31:0] acc1,
  input  logic [3:0]  uart_state,
  output logic        tx,
  output logic        busy,
  output logic [7:0]  frame_count,
  output logic        dropped
);

  localparam int            TW         = $clog2(PERIOD_CYCLES);
  localparam logic [TW-1:0] TIMER_LAST = TW'(PERIOD_CYCLES - 1);

  logic [TW-1:0] timer;
  logic          timer_exp;
  logic          req;

  tx_state_e     state;
  logic [3:0]    idx;
  snap_t         snap;
  logic [7:0]    chk_byte;
  logic [7:0]    ser_data;
  logic          ser_valid;
  logic          ser_ready;
  logic          ser_active;

  // Periodic timer keeps running through busy frames so the cadence is fixed
  assign timer_exp = enable && (timer == TIMER_LAST);
  assign req       = trigger || timer_exp;

  always_ff @(posedge clk_100mhz) begin
    if (rst || !enable || timer_exp) timer <= '0;
    else                             timer <= timer + 1'b1;
  end

  // Checksum over the payload; frame_count is stable for the whole frame
  always_comb begin
    chk_byte = '0;
    for (int i = IDX_SEQ; i < IDX_CHK; i++)
      chk_byte ^= payload_byte(snap, frame_count, 4'(i));
  end

  always_comb begin
    if (idx == 4'(IDX_SYNC))     ser_data = SYNC_BYTE;
    else if (idx == 4'(IDX_CHK)) ser_data = chk_byte;
    else                         ser_data = payload_byte(snap, frame_count, idx);
  end

  assign ser_valid = (state == SEND);

  always_ff @(posedge clk_100mhz) begin
    if (rst) begin
      state       <= IDLE;
      busy        <= 1'b0;
      frame_count <= '0;
      dropped     <= 1'b0;
      idx         <= '0;
      snap        <= '0;
    end else begin
      dropped <= req && busy;
      case (state)
        IDLE: if (req) begin
          snap        <= {acc_valid, mlp_layer, mlp_state, layer_complete,
                          uart_state, acc0, acc1};
          busy        <= 1'b1;
          frame_count <= frame_count + 8'd1;
          idx         <= '0;
          state       <= SEND;
        end
        SEND: if (ser_ready) begin
          if (idx == 4'(IDX_CHK)) state <= DRAIN;
          else                    idx   <= idx + 1'b1;
        end
        // in_ready rises in the last stop-bit cycle, so busy drops exactly
        // when the line time of the frame ends
        DRAIN: if (ser_ready || !ser_active) begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  uart_tx_serializer #(
    .CLOCK_FREQ (CLOCK_FREQ),
    .BAUD_RATE  (BAUD_RATE)
  ) u_ser (
    .clk_100mhz (clk_100mhz),
    .rst        (rst),
    .in_data    (ser_data),
    .in_valid   (ser_valid),
    .in_ready   (ser_ready),
    .tx         (tx),
    .tx_active  (ser_active)
  );

endmodule
